// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard scheduler (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0]  rs1_ID, rs2_ID;
  logic        rs1_used_ID, rs2_used_ID;
  logic [4:0]  rs1_EX, rs2_EX, rd_EX;
  logic        mem_read_EX, branch_taken_EX;
  logic        md_start_EX, md_is_div_EX;
  logic [4:0]  rd_MEM, rd_WB;
  logic        rf_wr_en_MEM, rf_wr_en_WB;
  logic        stall_IF, stall_ID, stall_EX;
  logic        flush_ID, flush_EX, pc_redirect;
  logic        md_busy, md_done;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rs1_EX, rs2_EX, rd_EX,
           mem_read_EX, branch_taken_EX, md_start_EX, md_is_div_EX,
           rd_MEM, rf_wr_en_MEM, rd_WB, rf_wr_en_WB,
    input  stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, pc_redirect,
           md_busy, md_done, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rs1_EX, rs2_EX, rd_EX,
           mem_read_EX, branch_taken_EX, md_start_EX, md_is_div_EX,
           rd_MEM, rf_wr_en_MEM, rd_WB, rf_wr_en_WB,
    output stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, pc_redirect,
           md_busy, md_done, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward scheduler for the 5-stage pipeline, with a MUL/DIV hold FSM
// and stall/redirect performance counters.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      stall_q, flush_q;

  logic       redirect, md_go, md_hold, md_last, load_use, stall_fe;
  logic [1:0] fa, fb;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we,  input logic [4:0] wb_rd);
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs)   return 2'b01;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
    else                                            return 2'b00;
  endfunction

  always_comb begin
    redirect = hz.branch_taken_EX;
    // A MUL/DIV sharing EX with a redirect never starts; the redirect wins.
    md_go    = (state == RUN) && hz.md_start_EX && !redirect;
    md_hold  = md_go || (state == BUSY && cnt != '0);
    md_last  = (state == BUSY) && (cnt == '0);
    load_use = hz.mem_read_EX && (hz.rd_EX != 5'd0) &&
               ((hz.rs1_used_ID && hz.rs1_ID == hz.rd_EX) ||
                (hz.rs2_used_ID && hz.rs2_ID == hz.rd_EX));
    stall_fe = !redirect && (md_hold || load_use);
    fa = fwd_sel(hz.rs1_EX, hz.rf_wr_en_MEM, hz.rd_MEM, hz.rf_wr_en_WB, hz.rd_WB);
    fb = fwd_sel(hz.rs2_EX, hz.rf_wr_en_MEM, hz.rd_MEM, hz.rf_wr_en_WB, hz.rd_WB);
  end

  assign hz.stall_IF    = !reset && stall_fe;
  assign hz.stall_ID    = !reset && stall_fe;
  assign hz.stall_EX    = !reset && !redirect && md_hold;
  assign hz.flush_ID    = !reset && redirect;
  // While MUL/DIV holds ID/EX, a load-use bubble would destroy the held instruction.
  assign hz.flush_EX    = !reset && (redirect || (load_use && !md_hold));
  assign hz.pc_redirect = !reset && redirect;
  assign hz.md_busy     = !reset && (state == BUSY);
  assign hz.md_done     = !reset && md_last;
  assign hz.fwd_a_sel   = reset ? 2'b00 : fa;
  assign hz.fwd_b_sel   = reset ? 2'b00 : fb;
  assign hz.stall_cnt   = reset ? 32'd0 : stall_q;
  assign hz.flush_cnt   = reset ? 32'd0 : flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      cnt     <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + {31'd0, stall_fe};
      flush_q <= flush_q + {31'd0, redirect};
      case (state)
        RUN: if (md_go) begin
          // The RUN cycle and the done cycle account for two of the LAT cycles.
          cnt   <= hz.md_is_div_EX ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
          state <= BUSY;
        end
        BUSY: begin
          if (cnt != '0) cnt   <= cnt - CNT_W'(1);
          else           state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control words are queued as each
// step is driven and popped for comparison mid-cycle.
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic [7:0]  flags;  // {stall_IF,stall_ID,stall_EX,flush_ID,flush_EX,pc_redirect,md_busy,md_done}
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } ctl_t;

  localparam bit [7:0] IDLE = 8'b0000_0000;
  localparam bit [7:0] LU   = 8'b1100_1000;
  localparam bit [7:0] MDST = 8'b1110_0000;
  localparam bit [7:0] MDBZ = 8'b1110_0010;
  localparam bit [7:0] DONE = 8'b0000_0011;
  localparam bit [7:0] RDR  = 8'b0001_1100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .hz(bus)
  );

  always #5 clk = ~clk;

  ctl_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk)
    if (!reset && bus.md_start_EX && bus.branch_taken_EX)
      $error("illegal stimulus: md_start_EX and branch_taken_EX both high");

  function automatic ctl_t e(input bit [7:0] f, input bit [1:0] a, input bit [1:0] b,
                             input int unsigned s, input int unsigned fl);
    ctl_t r;
    r.flags = f; r.fa = a; r.fb = b; r.sc = s; r.fc = fl;
    return r;
  endfunction

  task automatic clear_in();
    bus.rs1_ID = 5'd0; bus.rs2_ID = 5'd0; bus.rs1_used_ID = 1'b0; bus.rs2_used_ID = 1'b0;
    bus.rs1_EX = 5'd0; bus.rs2_EX = 5'd0; bus.rd_EX = 5'd0;
    bus.mem_read_EX = 1'b0; bus.branch_taken_EX = 1'b0;
    bus.md_start_EX = 1'b0; bus.md_is_div_EX = 1'b0;
    bus.rd_MEM = 5'd0; bus.rf_wr_en_MEM = 1'b0; bus.rd_WB = 5'd0; bus.rf_wr_en_WB = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    bus.mem_read_EX = 1'b1; bus.rd_EX = rd;
    bus.rs1_ID = rd; bus.rs1_used_ID = 1'b1;
  endtask

  task automatic step(input ctl_t x, input string tag);
    ctl_t obs, exp;
    sb.push_back(x);
    @(negedge clk);
    obs.flags = {bus.stall_IF, bus.stall_ID, bus.stall_EX, bus.flush_ID, bus.flush_EX,
                 bus.pc_redirect, bus.md_busy, bus.md_done};
    obs.fa = bus.fwd_a_sel; obs.fb = bus.fwd_b_sel;
    obs.sc = bus.stall_cnt; obs.fc = bus.flush_cnt;
    exp = sb.pop_front();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    load_use(5'd5);
    bus.rs1_EX = 5'd7; bus.rd_MEM = 5'd7; bus.rf_wr_en_MEM = 1'b1;
    step(e(IDLE, 2'b00, 2'b00, 0, 0), "reset0");
    step(e(IDLE, 2'b00, 2'b00, 0, 0), "reset1");
    reset = 1'b0;
    clear_in();
    step(e(IDLE, 2'b00, 2'b00, 0, 0), "idle");

    // Load to x0 never stalls.
    load_use(5'd0);
    step(e(IDLE, 2'b00, 2'b00, 0, 0), "ld_x0");
    // Load x5 used by rs1 in ID: one-cycle bubble.
    clear_in(); load_use(5'd5);
    step(e(LU, 2'b00, 2'b00, 0, 0), "ld_use");
    clear_in();
    step(e(IDLE, 2'b00, 2'b00, 1, 0), "ld_after");
    // Load-use through rs2 only.
    bus.mem_read_EX = 1'b1; bus.rd_EX = 5'd12; bus.rs2_ID = 5'd12; bus.rs2_used_ID = 1'b1;
    bus.rs1_ID = 5'd12;
    step(e(LU, 2'b00, 2'b00, 1, 0), "ld_use_rs2");
    clear_in();
    // rs matches but the operand is not read.
    bus.mem_read_EX = 1'b1; bus.rd_EX = 5'd12; bus.rs1_ID = 5'd12;
    step(e(IDLE, 2'b00, 2'b00, 2, 0), "ld_unused");

    // MUL, held in EX for MUL_LAT=3 cycles.
    clear_in(); bus.md_start_EX = 1'b1;
    step(e(MDST, 2'b00, 2'b00, 2, 0), "mul_c1");
    step(e(MDBZ, 2'b00, 2'b00, 3, 0), "mul_c2");
    step(e(DONE, 2'b00, 2'b00, 4, 0), "mul_c3");
    clear_in();
    step(e(IDLE, 2'b00, 2'b00, 4, 0), "mul_after");

    // DIV, DIV_LAT=16; load-use during BUSY must not flush EX.
    bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b1;
    step(e(MDST, 2'b00, 2'b00, 4, 0), "div_c1");
    for (int i = 2; i <= 15; i++) begin
      if (i == 5) load_use(5'd9);
      step(e(MDBZ, 2'b00, 2'b00, 4 + i - 1, 0), (i == 5) ? "div_lu" : "div_busy");
      if (i == 5) begin bus.mem_read_EX = 1'b0; bus.rd_EX = 5'd0; end
    end
    step(e(DONE, 2'b00, 2'b00, 19, 0), "div_done");
    clear_in();
    step(e(IDLE, 2'b00, 2'b00, 19, 0), "div_after");

    // Redirect beats a concurrent load-use.
    load_use(5'd5); bus.branch_taken_EX = 1'b1;
    step(e(RDR, 2'b00, 2'b00, 19, 0), "redirect");
    clear_in();
    step(e(IDLE, 2'b00, 2'b00, 19, 1), "redir_after");

    // Forwarding: MEM beats WB, WB alone, x0 never forwards.
    bus.rs1_EX = 5'd7; bus.rs2_EX = 5'd3; bus.rd_MEM = 5'd7; bus.rd_WB = 5'd7;
    bus.rf_wr_en_MEM = 1'b1; bus.rf_wr_en_WB = 1'b1;
    step(e(IDLE, 2'b01, 2'b00, 19, 1), "fwd_mem");
    bus.rf_wr_en_MEM = 1'b0;
    step(e(IDLE, 2'b10, 2'b00, 19, 1), "fwd_wb");
    bus.rs2_EX = 5'd7; bus.rf_wr_en_MEM = 1'b1; bus.rd_MEM = 5'd4; bus.rs1_EX = 5'd4;
    step(e(IDLE, 2'b01, 2'b10, 19, 1), "fwd_split");
    bus.rs1_EX = 5'd0; bus.rs2_EX = 5'd0; bus.rd_MEM = 5'd0; bus.rd_WB = 5'd0;
    step(e(IDLE, 2'b00, 2'b00, 19, 1), "fwd_x0");

    // Reset in the middle of a DIV aborts it and clears the counters.
    clear_in(); bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b1;
    step(e(MDST, 2'b00, 2'b00, 19, 1), "rdiv_c1");
    step(e(MDBZ, 2'b00, 2'b00, 20, 1), "rdiv_c2");
    reset = 1'b1;
    step(e(IDLE, 2'b00, 2'b00, 0, 0), "rdiv_rst");
    reset = 1'b0; clear_in();
    step(e(IDLE, 2'b00, 2'b00, 0, 0), "rdiv_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
